// File: rtl/pr_ctrl_pkg.sv
// Shared types for the partial-reconfiguration control path: sequencer states
// and status-bit positions used by the AXI-Lite register map.
package pr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    RECONFIG = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } pr_state_t;

  localparam int unsigned STS_OK_BIT       = 0;
  localparam int unsigned STS_DRAIN_TO_BIT = 1;
  localparam int unsigned STS_ICAP_ERR_BIT = 2;
  localparam int unsigned STS_ICAP_TO_BIT  = 3;
  localparam int unsigned STS_CNT_ERR_BIT  = 4;
  localparam int unsigned STS_W            = 5;

endpackage

// File: rtl/axi_outstanding_cnt.sv
// Saturating up/down counter of outstanding AXI transactions; err flags an
// increment at full scale or a decrement at zero in the current cycle.
module axi_outstanding_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q == CNT_MAX) err = 1'b1;
      else                  cnt_d = cnt_q + W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pr_decouple_sequencer.sv
// Sequences quiesce, drain, decouple, ICAP load and reset release of the
// NORTH role region. All outputs come straight from flops.
module pr_decouple_sequencer
  import pr_ctrl_pkg::*;
#(
  parameter int unsigned OUTSTANDING_W     = 6,
  parameter int unsigned DRAIN_TIMEOUT     = 4096,
  parameter int unsigned ICAP_TIMEOUT      = 2**24,
  parameter int unsigned RESET_HOLD_CYCLES = 16
) (
  input  logic       CLK_IN_250,
  input  logic       AXI_RESET_N,
  input  logic       pr_req,
  input  logic       icap_done,
  input  logic       icap_error,
  input  logic       mon_arvalid,
  input  logic       mon_arready,
  input  logic       mon_rvalid,
  input  logic       mon_rready,
  input  logic       mon_rlast,
  input  logic       mon_awvalid,
  input  logic       mon_awready,
  input  logic       mon_bvalid,
  input  logic       mon_bready,
  output logic       addr_gate,
  output logic       decouple,
  output logic       role_reset_n,
  output logic       icap_start,
  output logic       busy,
  output logic [2:0] state_o,
  output logic       sts_ok,
  output logic       sts_drain_to,
  output logic       sts_icap_err,
  output logic       sts_icap_to,
  output logic       sts_cnt_err
);

  localparam int unsigned TMR_MAX_A = (DRAIN_TIMEOUT > ICAP_TIMEOUT) ? DRAIN_TIMEOUT : ICAP_TIMEOUT;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > RESET_HOLD_CYCLES) ? TMR_MAX_A : RESET_HOLD_CYCLES;
  localparam int unsigned TMR_W     = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  pr_state_t          state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [STS_W-1:0]   sts_q, sts_d;
  logic addr_gate_q, addr_gate_d, decouple_q, decouple_d;
  logic role_reset_n_q, role_reset_n_d, icap_start_q, icap_start_d;
  logic busy_q, busy_d;

  logic [OUTSTANDING_W-1:0] rd_cnt, wr_cnt;
  logic rd_err, wr_err, cnt_clr, entering;

  axi_outstanding_cnt #(.W(OUTSTANDING_W)) u_rd_cnt (
    .clk(CLK_IN_250), .rst_n(AXI_RESET_N), .clr(cnt_clr),
    .inc(mon_arvalid && mon_arready),
    .dec(mon_rvalid && mon_rready && mon_rlast),
    .cnt(rd_cnt), .err(rd_err)
  );

  axi_outstanding_cnt #(.W(OUTSTANDING_W)) u_wr_cnt (
    .clk(CLK_IN_250), .rst_n(AXI_RESET_N), .clr(cnt_clr),
    .inc(mon_awvalid && mon_awready),
    .dec(mon_bvalid && mon_bready),
    .cnt(wr_cnt), .err(wr_err)
  );

  // Timer is loaded with (duration-1) and the state's exit fires when it reaches 0.
  function automatic logic [TMR_W-1:0] tmr_load(pr_state_t s);
    case (s)
      DRAIN:    return TMR_W'(DRAIN_TIMEOUT - 1);
      RECONFIG: return TMR_W'(ICAP_TIMEOUT - 1);
      HOLD:     return TMR_W'(RESET_HOLD_CYCLES - 1);
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    sts_d   = sts_q;
    tmr_d   = (tmr_q != '0) ? tmr_q - TMR_W'(1) : '0;

    unique case (state_q)
      IDLE: if (pr_req) begin
        sts_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (rd_cnt == '0 && wr_cnt == '0) begin
          state_d = RECONFIG;
        end else if (tmr_q == '0) begin
          sts_d[STS_DRAIN_TO_BIT] = 1'b1;
          state_d = RECONFIG;
        end
      end
      RECONFIG: begin
        if (icap_error) begin
          sts_d[STS_ICAP_ERR_BIT] = 1'b1;
          state_d = HOLD;
        end else if (icap_done) begin
          sts_d[STS_OK_BIT] = 1'b1;
          state_d = HOLD;
        end else if (tmr_q == '0) begin
          sts_d[STS_ICAP_TO_BIT] = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD:    if (tmr_q == '0) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_err || wr_err) sts_d[STS_CNT_ERR_BIT] = 1'b1;

    entering = (state_d != state_q);
    if (entering) tmr_d = tmr_load(state_d);
    cnt_clr = entering && (state_d == RECONFIG);

    // Outputs are decoded from the next state so they line up with state_o.
    addr_gate_d    = (state_d inside {DRAIN, RECONFIG, HOLD});
    decouple_d     = (state_d inside {RECONFIG, HOLD});
    role_reset_n_d = (state_d inside {IDLE, DRAIN});
    icap_start_d   = cnt_clr;
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge CLK_IN_250) begin
    if (!AXI_RESET_N) begin
      state_q        <= IDLE;
      tmr_q          <= '0;
      sts_q          <= '0;
      addr_gate_q    <= 1'b0;
      decouple_q     <= 1'b0;
      role_reset_n_q <= 1'b0;
      icap_start_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      sts_q          <= sts_d;
      addr_gate_q    <= addr_gate_d;
      decouple_q     <= decouple_d;
      role_reset_n_q <= role_reset_n_d;
      icap_start_q   <= icap_start_d;
      busy_q         <= busy_d;
    end
  end

  assign state_o      = state_q;
  assign addr_gate    = addr_gate_q;
  assign decouple     = decouple_q;
  assign role_reset_n = role_reset_n_q;
  assign icap_start   = icap_start_q;
  assign busy         = busy_q;
  assign sts_ok       = sts_q[STS_OK_BIT];
  assign sts_drain_to = sts_q[STS_DRAIN_TO_BIT];
  assign sts_icap_err = sts_q[STS_ICAP_ERR_BIT];
  assign sts_icap_to  = sts_q[STS_ICAP_TO_BIT];
  assign sts_cnt_err  = sts_q[STS_CNT_ERR_BIT];

endmodule

// File: tb/tb_pr_decouple_sequencer.sv
// Directed and randomized checks of pr_decouple_sequencer against a
// cycle-level behavioural model built from elapsed-time and count arithmetic.
module tb_pr_decouple_sequencer;

  localparam int OW   = 2;
  localparam int DT   = 8;
  localparam int IT   = 40;
  localparam int RH   = 16;
  localparam int CMAX = (1 << OW) - 1;

  logic clk = 1'b0;
  logic AXI_RESET_N = 1'b0;
  logic pr_req = 1'b0, icap_done = 1'b0, icap_error = 1'b0;
  logic mon_arvalid = 1'b0, mon_arready = 1'b0;
  logic mon_rvalid = 1'b0, mon_rready = 1'b0, mon_rlast = 1'b0;
  logic mon_awvalid = 1'b0, mon_awready = 1'b0;
  logic mon_bvalid = 1'b0, mon_bready = 1'b0;
  logic addr_gate, decouple, role_reset_n, icap_start, busy;
  logic [2:0] state_o;
  logic sts_ok, sts_drain_to, sts_icap_err, sts_icap_to, sts_cnt_err;

  pr_decouple_sequencer #(
    .OUTSTANDING_W(OW), .DRAIN_TIMEOUT(DT), .ICAP_TIMEOUT(IT), .RESET_HOLD_CYCLES(RH)
  ) dut (
    .CLK_IN_250(clk), .AXI_RESET_N(AXI_RESET_N), .pr_req(pr_req),
    .icap_done(icap_done), .icap_error(icap_error),
    .mon_arvalid(mon_arvalid), .mon_arready(mon_arready),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
    .mon_awvalid(mon_awvalid), .mon_awready(mon_awready),
    .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
    .addr_gate(addr_gate), .decouple(decouple), .role_reset_n(role_reset_n),
    .icap_start(icap_start), .busy(busy), .state_o(state_o),
    .sts_ok(sts_ok), .sts_drain_to(sts_drain_to), .sts_icap_err(sts_icap_err),
    .sts_icap_to(sts_icap_to), .sts_cnt_err(sts_cnt_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Behavioural model: state id, cycles spent in the state, outstanding counts.
  int m_st = 0, m_el = 0, m_rd = 0, m_wr = 0;
  bit [4:0] m_sts = '0;
  bit m_gate = 0, m_dec = 0, m_rrn = 0, m_start = 0, m_busy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
  endtask

  function automatic logic [31:0] obs_vec();
    return 32'({state_o, addr_gate, decouple, role_reset_n, icap_start, busy,
                sts_cnt_err, sts_icap_to, sts_icap_err, sts_drain_to, sts_ok});
  endfunction

  function automatic logic [31:0] exp_vec();
    return 32'({3'(m_st), m_gate, m_dec, m_rrn, m_start, m_busy, m_sts});
  endfunction

  task automatic model_step();
    int ns, nrd, nwr;
    bit ar_hs, r_hs, aw_hs, b_hs;
    ar_hs = mon_arvalid && mon_arready;
    r_hs  = mon_rvalid && mon_rready && mon_rlast;
    aw_hs = mon_awvalid && mon_awready;
    b_hs  = mon_bvalid && mon_bready;
    if (!AXI_RESET_N) begin
      m_st = 0; m_el = 0; m_rd = 0; m_wr = 0; m_sts = '0;
      m_gate = 0; m_dec = 0; m_rrn = 0; m_start = 0; m_busy = 0;
      return;
    end
    ns = m_st;
    case (m_st)
      0: if (pr_req) begin m_sts = '0; ns = 1; end
      1: if (m_rd == 0 && m_wr == 0) ns = 2;
         else if (m_el == DT - 1) begin m_sts[1] = 1; ns = 2; end
      2: if (icap_error) begin m_sts[2] = 1; ns = 3; end
         else if (icap_done) begin m_sts[0] = 1; ns = 3; end
         else if (m_el == IT - 1) begin m_sts[3] = 1; ns = 3; end
      3: if (m_el == RH - 1) ns = 4;
      default: ns = 0;
    endcase
    if (ns == 2 && m_st != 2) begin
      m_rd = 0; m_wr = 0;
    end else begin
      nrd = m_rd + int'(ar_hs) - int'(r_hs);
      nwr = m_wr + int'(aw_hs) - int'(b_hs);
      if (nrd < 0 || nrd > CMAX) m_sts[4] = 1; else m_rd = nrd;
      if (nwr < 0 || nwr > CMAX) m_sts[4] = 1; else m_wr = nwr;
    end
    m_start = (ns == 2 && m_st != 2);
    m_el    = (ns == m_st) ? m_el + 1 : 0;
    m_st    = ns;
    m_gate  = (ns >= 1 && ns <= 3);
    m_dec   = (ns == 2 || ns == 3);
    m_rrn   = (ns <= 1);
    m_busy  = (ns != 0);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      check("model", obs_vec(), exp_vec());
    end
  endtask

  task automatic wait_state(input int target, input int budget);
    int n;
    n = 0;
    while (state_o !== 3'(target) && n < budget) begin
      step();
      n++;
    end
    check("wait_state", 32'(state_o), 32'(target));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset and first idle cycle
    step(3);
    check("reset_outputs", obs_vec(), 32'd0);
    AXI_RESET_N = 1'b1;
    step();
    check("rrn_first_idle", 32'(role_reset_n), 32'd1);
    icap_done = 1'b1; step(); icap_done = 1'b0;
    check("done_ignored_idle", 32'(sts_ok), 32'd0);

    // Idle PR with nothing outstanding
    pr_req = 1'b1; step(); pr_req = 1'b0;
    check("drain_entry", 32'(state_o), 32'd1);
    step();
    check("reconfig_entry", 32'(state_o), 32'd2);
    check("icap_start_pulse", 32'(icap_start), 32'd1);
    check("decouple_reconfig", 32'({decouple, role_reset_n}), 32'b10);
    step();
    check("icap_start_once", 32'(icap_start), 32'd0);
    step(10);
    icap_done = 1'b1; step(); icap_done = 1'b0;
    check("hold_entry", 32'({state_o, sts_ok}), 32'({3'd3, 1'b1}));
    step(15);
    check("hold_last", 32'(state_o), 32'd3);
    step();
    check("release", 32'({state_o, decouple, role_reset_n, addr_gate}), 32'({3'd4, 3'b000}));
    step();
    check("idle_after_release", 32'({state_o, role_reset_n, sts_ok, busy}), 32'({3'd0, 3'b110}));

    // Drain with 3 reads and 2 writes outstanding
    mon_arvalid = 1'b1; mon_arready = 1'b1; step(3); mon_arvalid = 1'b0;
    mon_awvalid = 1'b1; mon_awready = 1'b1; step(2); mon_awvalid = 1'b0;
    pr_req = 1'b1; step(); pr_req = 1'b0;
    check("drain_gate", 32'({state_o, addr_gate}), 32'({3'd1, 1'b1}));
    mon_arvalid = !addr_gate; step(); mon_arvalid = 1'b0;
    mon_rvalid = 1'b1; mon_rready = 1'b1; mon_rlast = 1'b1; step(3);
    mon_rvalid = 1'b0; mon_rlast = 1'b0;
    mon_bvalid = 1'b1; mon_bready = 1'b1; step(2); mon_bvalid = 1'b0;
    check("drain_still", 32'(state_o), 32'd1);
    step();
    check("drain_done", 32'({state_o, sts_drain_to}), 32'({3'd2, 1'b0}));
    icap_done = 1'b1; step(); icap_done = 1'b0;
    wait_state(0, 40);

    // Drain timeout with one write never answered
    mon_awvalid = 1'b1; step(); mon_awvalid = 1'b0;
    pr_req = 1'b1; step(); pr_req = 1'b0;
    step(7);
    check("drain_wait", 32'(state_o), 32'd1);
    step();
    check("drain_timeout", 32'({state_o, sts_drain_to}), 32'({3'd2, 1'b1}));
    icap_error = 1'b1; step(); icap_error = 1'b0;
    check("icap_err", 32'({state_o, sts_icap_err, sts_ok}), 32'({3'd3, 2'b10}));
    wait_state(0, 40);
    pr_req = 1'b1; step(); pr_req = 1'b0;
    step();
    check("wr_cleared", 32'({state_o, sts_drain_to}), 32'({3'd2, 1'b0}));

    // ICAP timeout
    step(39);
    check("icap_wait", 32'(state_o), 32'd2);
    step();
    check("icap_timeout", 32'({state_o, sts_icap_to}), 32'({3'd3, 1'b1}));
    wait_state(0, 40);

    // done + error together, pr_req during HOLD ignored
    pr_req = 1'b1; step(); pr_req = 1'b0;
    step();
    icap_done = 1'b1; icap_error = 1'b1; step(); icap_done = 1'b0; icap_error = 1'b0;
    check("both_pulses", 32'({state_o, sts_icap_err, sts_ok}), 32'({3'd3, 2'b10}));
    step(8);
    pr_req = 1'b1; step(); pr_req = 1'b0;
    check("pr_req_hold_ignored", 32'(state_o), 32'd3);
    wait_state(0, 40);
    step(2);
    check("no_restart", 32'(state_o), 32'd0);

    // Reset during RECONFIG
    pr_req = 1'b1; step(); pr_req = 1'b0;
    step(4);
    check("pre_reset_reconfig", 32'(state_o), 32'd2);
    AXI_RESET_N = 1'b0; step(); AXI_RESET_N = 1'b1;
    check("mid_reset", 32'({state_o, decouple, role_reset_n, busy}), 32'd0);
    step();
    check("rrn_after_mid_reset", 32'(role_reset_n), 32'd1);

    // Counter saturation and underflow
    mon_arvalid = 1'b1; mon_arready = 1'b1; step(4); mon_arvalid = 1'b0;
    check("sat_err", 32'(sts_cnt_err), 32'd1);
    mon_rvalid = 1'b1; mon_rready = 1'b1; mon_rlast = 1'b1; step(2);
    mon_rvalid = 1'b0; mon_rlast = 1'b0;
    pr_req = 1'b1; step(); pr_req = 1'b0;
    check("sticky_cleared", 32'({state_o, sts_cnt_err}), 32'({3'd1, 1'b0}));
    step(8);
    check("sat_held", 32'({state_o, sts_drain_to}), 32'({3'd2, 1'b1}));
    icap_done = 1'b1; step(); icap_done = 1'b0;
    wait_state(0, 40);
    mon_bvalid = 1'b1; mon_bready = 1'b1; step(); mon_bvalid = 1'b0;
    check("underflow_err", 32'(sts_cnt_err), 32'd1);

    // Randomized traffic, requests, ICAP pulses and occasional resets
    for (int i = 0; i < 1500; i++) begin
      AXI_RESET_N = ($urandom_range(499) != 0);
      pr_req      = ($urandom_range(39) == 0);
      icap_done   = ($urandom_range(24) == 0);
      icap_error  = ($urandom_range(59) == 0);
      mon_arvalid = ($urandom_range(3) == 0) && !addr_gate;
      mon_arready = $urandom_range(1);
      mon_awvalid = ($urandom_range(3) == 0) && !addr_gate;
      mon_awready = $urandom_range(1);
      mon_rvalid  = ($urandom_range(3) == 0);
      mon_rready  = $urandom_range(1);
      mon_rlast   = $urandom_range(1);
      mon_bvalid  = ($urandom_range(3) == 0);
      mon_bready  = $urandom_range(1);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
